// File: rtl/four_input_switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce_pkg
// Description : Shared constants and channel state type for the
//               four_input_switch_debouncer block.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debounce_pkg;

  // Number of independent switch channels
  localparam int NUM_CH = 4;

  // Default configuration for a 50 MHz system clock (about 1 ms debounce)
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_CNT_W           = 16;

  // Per-channel filter state
  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } ch_state_e;

endpackage : switch_debounce_pkg
`default_nettype wire

// File: rtl/four_input_switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : four_input_switch_debouncer_if
// Description : Switch bus between raw inputs and the debounced levels /
//               edge pulses. master = stimulus side, slave = debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface four_input_switch_debouncer_if;
  import switch_debounce_pkg::*;

  logic [NUM_CH-1:0] sw_in;
  logic [NUM_CH-1:0] sw_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  modport master (
    output sw_in,
    input  sw_out,
    input  rise,
    input  fall
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output rise,
    output fall
  );

endinterface : four_input_switch_debouncer_if
`default_nettype wire

// File: rtl/four_input_switch_debouncer_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One switch channel: SYNC_STAGES-deep synchronizer followed by
//               a counter-based debounce filter. The output follows the
//               synchronized input only after it has differed for a full
//               debounce window; any return to the current level restarts.
//               Optional macro EDGE_PULSE_EN adds registered rise/fall pulses;
//               without it rise_o/fall_o are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  // Reject configurations the counter cannot represent without wrapping
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("debounce_channel: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cnt_w
    $error("debounce_channel: 2**CNT_W must exceed DEBOUNCE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_last;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;

  // Shift the raw level through the synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign s_last = sync_q[SYNC_STAGES-1];

  // Filter state, counter and debounced level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic: a mismatch first arms COUNTING, then the window runs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (s_last != out_q) begin
          state_d = ST_COUNTING;
        end
      end
      ST_COUNTING: begin
        if (s_last == out_q) begin
          // Bounce back to the current level: discard the partial window
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          out_d   = s_last;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_o = out_q;

`ifdef EDGE_PULSE_EN
  logic rise_q;
  logic fall_q;

  // Edge pulses registered on the same edge that the debounced level moves
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule : debounce_channel
`default_nettype wire

// File: rtl/four_input_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : four_input_switch_debouncer
// Description : Four independent synchronizer + debounce channels feeding the
//               A..D inputs of the downstream NOR stage (sw_out[0..3]).
//               Macro EDGE_PULSE_EN enables the rise/fall pulse outputs;
//               otherwise they read as 4'b0000.
// Revision    : 1.0 - initial release
// ============================================================================
module four_input_switch_debouncer
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  four_input_switch_debouncer_if.slave  bus
);

  logic [NUM_CH-1:0] sw_out_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] fall_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .sw_i   (bus.sw_in[i]),
      .sw_o   (sw_out_w[i]),
      .rise_o (rise_w[i]),
      .fall_o (fall_w[i])
    );
  end

  assign bus.sw_out = sw_out_w;
  assign bus.rise   = rise_w;
  assign bus.fall   = fall_w;

endmodule : four_input_switch_debouncer
`default_nettype wire

// File: tb/tb_four_input_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_input_switch_debouncer
// Description : Self-checking bench: table of per-edge vectors, a hand-written
//               reset-mid-count sequence, then random switch activity checked
//               against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_input_switch_debouncer;

  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int CW  = 3;
  localparam int LAT = SS + DC;

`ifdef EDGE_PULSE_EN
  localparam logic [3:0] EDGE_MASK = 4'b1111;
`else
  localparam logic [3:0] EDGE_MASK = 4'b0000;
`endif

  logic clk;
  logic rst;

  four_input_switch_debouncer_if bus ();

  four_input_switch_debouncer #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    logic [3:0] sw;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a channel output follows the synchronized input once it
  // has disagreed with the output on LAT-SS+1 consecutive edges.
  logic [SS-1:0] m_sync [4];
  int            m_run  [4];
  logic [3:0]    m_out  = '0;
  logic [3:0]    m_rise = '0;
  logic [3:0]    m_fall = '0;

  task automatic model_edge(input bit r, input logic [3:0] sw);
    logic [3:0] s_last;
    for (int c = 0; c < 4; c++) s_last[c] = m_sync[c][SS-1];
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      m_out = '0;
      for (int c = 0; c < 4; c++) begin
        m_sync[c] = '0;
        m_run[c]  = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (s_last[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == DC + 1) begin
            m_out[c]  = s_last[c];
            m_rise[c] = s_last[c];
            m_fall[c] = ~s_last[c];
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_sync[c] = {m_sync[c][SS-2:0], sw[c]};
      end
      m_rise = m_rise & EDGE_MASK;
      m_fall = m_fall & EDGE_MASK;
    end
  endtask

  task automatic check(input string nm, input logic [3:0] eo, input logic [3:0] er,
                       input logic [3:0] ef);
    n_vec++;
    if (bus.sw_out !== eo || bus.rise !== er || bus.fall !== ef) begin
      n_err++;
      $display("FAIL %s @%0t: got out=%b rise=%b fall=%b, want out=%b rise=%b fall=%b",
               nm, $time, bus.sw_out, bus.rise, bus.fall, eo, er, ef);
    end
  endtask

  // One clock edge: drive, advance the model on the edge, compare 1 time unit later
  task automatic step(input bit r, input logic [3:0] sw, input bit use_model,
                      input logic [3:0] eo, input logic [3:0] er, input logic [3:0] ef,
                      input string nm);
    rst       = r;
    bus.sw_in = sw;
    @(posedge clk);
    model_edge(r, sw);
    #1;
    if (use_model) check(nm, m_out, m_rise, m_fall);
    else           check(nm, eo, er & EDGE_MASK, ef & EDGE_MASK);
  endtask

  function automatic void add_row(bit r, logic [3:0] sw, logic [3:0] o, logic [3:0] ri,
                                  logic [3:0] fa, string nm);
    tbl.push_back('{r, sw, o, ri, fa, nm});
  endfunction

  // Hold a new input level: old output for edges 0..LAT-1, new one at edge LAT
  function automatic void add_hold(logic [3:0] from, logic [3:0] to, int tail, string nm);
    for (int e = 0; e < LAT; e++) add_row(1'b0, to, from, 4'b0, 4'b0, nm);
    add_row(1'b0, to, to, to & ~from, from & ~to, {nm, "_edge"});
    for (int e = 0; e < tail; e++) add_row(1'b0, to, to, 4'b0, 4'b0, {nm, "_after"});
  endfunction

  initial begin
    logic [3:0] cur;
    bit         r;

    rst       = 1'b1;
    bus.sw_in = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      m_sync[c] = '0;
      m_run[c]  = 0;
    end

    // ---------------- table-driven vectors ----------------
    for (int k = 0; k < 3; k++) add_row(1'b1, 4'b1111, 4'b0, 4'b0, 4'b0, "reset_hold");
    add_hold(4'b0000, 4'b1111, 1, "reset_release");
    add_hold(4'b1111, 4'b0111, 1, "release_ch3");
    add_hold(4'b0111, 4'b0000, 1, "all_low");
    add_hold(4'b0000, 4'b0001, 1, "press_ch0");
    for (int k = 0; k < 3; k++) add_row(1'b0, 4'b0011, 4'b0001, 4'b0, 4'b0, "bounce_ch1");
    for (int k = 0; k < 8; k++) add_row(1'b0, 4'b0001, 4'b0001, 4'b0, 4'b0, "bounce_settle");
    add_hold(4'b0001, 4'b0011, 1, "press_ch1_after_bounce");
    add_hold(4'b0011, 4'b0000, 1, "clear");
    add_hold(4'b0000, 4'b1111, 2, "simultaneous");
    add_hold(4'b1111, 4'b0000, 1, "simul_release");

    foreach (tbl[k]) step(tbl[k].r, tbl[k].sw, 1'b0, tbl[k].out, tbl[k].rise, tbl[k].fall,
                          tbl[k].name);

    // ---------------- reset in the middle of a count ----------------
    for (int e = 0; e < 4; e++) step(1'b0, 4'b0100, 1'b0, 4'b0, 4'b0, 4'b0, "midrst_pre");
    step(1'b1, 4'b0100, 1'b0, 4'b0, 4'b0, 4'b0, "midrst_rst");
    for (int e = 5; e < 11; e++) step(1'b0, 4'b0100, 1'b0, 4'b0, 4'b0, 4'b0, "midrst_wait");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0, "midrst_edge11");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0, 4'b0, "midrst_after");

    // ---------------- randomized activity vs. reference model ----------------
    cur = 4'b0100;
    for (int cyc = 0; cyc < 800; cyc++) begin
      r = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      end
      step(r, cur, 1'b1, 4'b0, 4'b0, 4'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_four_input_switch_debouncer
`default_nettype wire
